game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 30 +++
 rtl/game_sequencer_tick_divider.sv | 30 +++
 rtl/game_sequencer.sv | 111 +++++++++++
 tb/tb_game_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and defaults for the game sequencer.
// State codes are also exported on the debug state port.
package game_sequencer_pkg;

  localparam int TICK_DIV_DEF    = 25000;
  localparam int LIVES_DEF       = 3;
  localparam int PAUSE_TICKS_DEF = 32;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_RESUME    = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  function automatic logic [LEVEL_W-1:0] level_inc(
    input logic [LEVEL_W-1:0] lvl
  );
    if (lvl == {LEVEL_W{1'b1}})
      return lvl;
    return lvl + 1'b1;
  endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Free-running game-tick divider.
// tick is decoded from the registered count only.
import game_sequencer_pkg::*;

module tick_divider #(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] r_cnt;
  logic        w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (!reset)
      r_cnt <= '0;
    else if (w_last)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow FSM: start, play, pause, resume, game over.
// All outputs come from registered state and the registered divider.
import game_sequencer_pkg::*;

module game_sequencer #(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int LIVES       = LIVES_DEF,
  parameter int PAUSE_TICKS = PAUSE_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startPulse,
  input  logic               shipHit,
  input  logic               waveCleared,
  input  logic               invadersLanded,
  output logic               enable,
  output logic               clear,
  output logic               scoreClear,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               gameOver,
  output logic [STATE_W-1:0] state
);

  localparam logic [7:0]         PT8 = 8'(PAUSE_TICKS);
  localparam logic [LIVES_W-1:0] LV0 = LIVES_W'(LIVES);

  state_e             r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [LEVEL_W-1:0] r_level;
  logic [7:0]         r_pcnt;
  logic               w_tick;
  logic [7:0]         w_pcnt_nx;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  assign w_pcnt_nx = r_pcnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_lives <= '0;
      r_level <= '0;
      r_pcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (startPulse)
            r_state <= ST_INIT;
        end
        ST_INIT: begin
          r_lives <= LV0;
          r_level <= '0;
          r_state <= ST_PLAYING;
        end
        ST_PLAYING: begin
          if (invadersLanded) begin
            r_lives <= '0;
            r_state <= ST_GAME_OVER;
          end else if (shipHit) begin
            if (r_lives == LIVES_W'(1)) begin
              r_lives <= '0;
              r_state <= ST_GAME_OVER;
            end else begin
              r_lives <= r_lives - 1'b1;
              r_pcnt  <= '0;
              r_state <= ST_PAUSE;
            end
          end else if (waveCleared) begin
            r_level <= level_inc(r_level);
            r_pcnt  <= '0;
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // counter lands on PAUSE_TICKS together with the RESUME move
          if (w_tick) begin
            r_pcnt <= w_pcnt_nx;
            if (w_pcnt_nx == PT8)
              r_state <= ST_RESUME;
          end
        end
        ST_RESUME: begin
          r_state <= ST_PLAYING;
        end
        ST_GAME_OVER: begin
          if (startPulse)
            r_state <= ST_INIT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign enable     = w_tick && (r_state == ST_PLAYING);
  assign clear      = (r_state == ST_INIT) || (r_state == ST_RESUME);
  assign scoreClear = (r_state == ST_INIT);
  assign gameOver   = (r_state == ST_GAME_OVER);
  assign lives      = r_lives;
  assign level      = r_level;
  assign state      = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (TICK_DIV=4, LIVES=3, PAUSE_TICKS=2).
// Expected state snapshots are queued by stimulus and popped on each state change.
module tb_game_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lv;
    logic [3:0] lvl;
    logic       clr;
    logic       sclr;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startPulse = 1'b0;
  logic       shipHit = 1'b0;
  logic       waveCleared = 1'b0;
  logic       invadersLanded = 1'b0;
  logic       enable;
  logic       clear;
  logic       scoreClear;
  logic [1:0] lives;
  logic [3:0] level;
  logic       gameOver;
  logic [2:0] state;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_DIV   (4),
    .LIVES      (3),
    .PAUSE_TICKS(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startPulse    (startPulse),
    .shipHit       (shipHit),
    .waveCleared   (waveCleared),
    .invadersLanded(invadersLanded),
    .enable        (enable),
    .clear         (clear),
    .scoreClear    (scoreClear),
    .lives         (lives),
    .level         (level),
    .gameOver      (gameOver),
    .state         (state)
  );

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  bit   mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;
  logic prev_clr = 1'b0;
  int   en_bad = 0;
  int   cc_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic [1:0] lv,
                              input logic [3:0] lvl, input logic clr,
                              input logic sclr, input logic go);
    exp_t e;
    e.st = st; e.lv = lv; e.lvl = lvl;
    e.clr = clr; e.sclr = sclr; e.go = go;
    return e;
  endfunction

  // monitor: every observed state change must match the next queued snapshot
  always @(negedge clk) begin
    if (mon_en) begin
      if (enable && state != 3'd2) en_bad++;
      if (clear && prev_clr) cc_bad++;
      prev_clr = clear;
      if (state != prev_st) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_transition: got %0d expected %0d", state, prev_st);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("transition", int'({state, lives, level, clear, scoreClear, gameOver}),
              int'(e));
        end
        prev_st = state;
      end
    end
  end

  task automatic pulse(input logic [3:0] m);
    @(posedge clk); #1;
    {startPulse, shipHit, waveCleared, invadersLanded} = m;
    @(posedge clk); #1;
    {startPulse, shipHit, waveCleared, invadersLanded} = 4'b0000;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    for (int i = 0; i < 200 && state !== s; i++) @(negedge clk);
    chk(nm, int'(state), int'(s));
  endtask

  task automatic push_cycle(input logic [1:0] lv, input logic [3:0] lvl);
    q.push_back(mk(3'd3, lv, lvl, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(3'd4, lv, lvl, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'd2, lv, lvl, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    int cnt, first, second;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_lives_level", int'({lives, level}), 0);
    chk("reset_strobes", int'({enable, clear, scoreClear, gameOver}), 0);
    reset = 1'b1;
    prev_st = state;
    mon_en = 1'b1;

    q.push_back(mk(3'd1, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(3'd2, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0));
    pulse(4'b1000);
    wait_state(3'd2, "start_to_playing");

    cnt = 0; first = -1; second = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (enable) begin
        cnt++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    chk("enable_count", cnt, 4);
    chk("enable_period", second - first, 4);

    pulse(4'b1000);
    repeat (10) @(negedge clk);
    chk("start_ignored_playing", int'(state), 2);

    push_cycle(2'd2, 4'd0);
    pulse(4'b0100);
    pulse(4'b0100);
    wait_state(3'd2, "hit1_back_to_play");
    chk("hit1_lives", int'(lives), 2);

    push_cycle(2'd1, 4'd0);
    pulse(4'b0100);
    wait_state(3'd2, "hit2_back_to_play");

    q.push_back(mk(3'd5, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    pulse(4'b0100);
    wait_state(3'd5, "hit3_game_over");
    chk("hit3_gameover_flag", int'(gameOver), 1);
    pulse(4'b0110);
    repeat (6) @(negedge clk);
    chk("events_ignored_gameover", int'(state), 5);

    q.push_back(mk(3'd1, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(3'd2, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0));
    pulse(4'b1000);
    wait_state(3'd2, "restart1");
    chk("restart1_lives", int'(lives), 3);

    push_cycle(2'd3, 4'd1);
    pulse(4'b0010);
    wait_state(3'd2, "wave1");

    q.push_back(mk(3'd5, 2'd0, 4'd1, 1'b0, 1'b0, 1'b1));
    pulse(4'b0111);
    wait_state(3'd5, "triple_game_over");
    chk("triple_level_kept", int'(level), 1);

    q.push_back(mk(3'd1, 2'd0, 4'd1, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(3'd2, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0));
    pulse(4'b1000);
    wait_state(3'd2, "restart2");

    for (int k = 1; k <= 16; k++) begin
      push_cycle(2'd3, (k > 15) ? 4'd15 : 4'(k));
      pulse(4'b0010);
      wait_state(3'd2, "wave_loop");
    end
    chk("level_saturated", int'(level), 15);

    q.push_back(mk(3'd3, 2'd3, 4'd15, 1'b0, 1'b0, 1'b0));
    pulse(4'b0010);
    repeat (2) @(negedge clk);
    q.push_back(mk(3'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("midpause_reset_state", int'(state), 0);
    chk("midpause_reset_outs",
        int'({lives, level, enable, clear, scoreClear, gameOver}), 0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_after_reset", int'(state), 0);

    chk("enable_only_playing", en_bad, 0);
    chk("clear_not_back_to_back", cc_bad, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
